// File: rtl/fp_addsub_if.sv
// Operand/result handshake bundle for fp_addsub_pipe.
// The master side issues operands and accepts results; the slave side is the adder.
interface fp_addsub_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = EXP_W + MAN_W + 1;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [3:0]   flags;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, result, flags
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, result, flags
    );
endinterface

// File: rtl/fp_addsub_pipe.sv
// Four-stage IEEE-754 adder/subtractor: align, add/sub, normalise, round/pack.
// Subnormals flush to zero, rounding is nearest-even, one global stall enable.
module fp_addsub_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic        clk,
    input  logic        rst_n,
    fp_addsub_if.slave  io
);
    localparam int W    = EXP_W + MAN_W + 1;
    localparam int M4   = MAN_W + 4;           // {hidden, frac, G, R, S}
    localparam int LZ_W = $clog2(M4 + 1);
    localparam int EE_W = EXP_W + 2;           // signed exponent during normalise/round

    localparam logic [W-1:0]    QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic [EE_W-1:0] EXP_MAX = {2'b00, {EXP_W{1'b1}}};

    typedef struct packed {
        logic         spec;
        logic [W-1:0] spec_res;
        logic         spec_inv;
        logic         sign;
    } ctl_t;

    typedef struct packed {
        ctl_t             ctl;
        logic             eff_sub;
        logic [EXP_W-1:0] exp;
        logic [M4-1:0]    man_l;
        logic [M4-1:0]    man_s;
    } s1_t;

    typedef struct packed {
        ctl_t             ctl;
        logic [EXP_W-1:0] exp;
        logic [M4:0]      sum;
    } s2_t;

    typedef struct packed {
        ctl_t            ctl;
        logic [EE_W-1:0] exp;
        logic [M4-1:0]   norm;
    } s3_t;

    logic advance;
    logic v1, v2, v3, out_valid_q;
    logic [W-1:0] result_q, result_d;
    logic [3:0]   flags_q, flags_d;
    s1_t s1_d, s1_q;
    s2_t s2_d, s2_q;
    s3_t s3_d, s3_q;

    assign advance      = !out_valid_q || io.out_ready;
    assign io.in_ready  = advance;
    assign io.out_valid = out_valid_q;
    assign io.result    = result_q;
    assign io.flags     = flags_q;

    // ---------------- S1: classify, swap, align ----------------
    logic             sa, sb, sl;
    logic [EXP_W-1:0] ea, eb, el, es, diff;
    logic [MAN_W-1:0] fa, fb, fl, fs;
    logic             a_nan, a_inf, a_zero, b_nan, b_inf, b_zero, swap;
    logic [M4-1:0]    ext_s;
    logic [2*M4-1:0]  wide;

    assign sa = io.a[W-1];
    assign ea = io.a[W-2:MAN_W];
    assign fa = io.a[MAN_W-1:0];
    assign sb = io.b[W-1] ^ io.op;
    assign eb = io.b[W-2:MAN_W];
    assign fb = io.b[MAN_W-1:0];

    assign a_nan  = (&ea) & (|fa);
    assign a_inf  = (&ea) & ~(|fa);
    assign a_zero = ~(|ea);
    assign b_nan  = (&eb) & (|fb);
    assign b_inf  = (&eb) & ~(|fb);
    assign b_zero = ~(|eb);

    assign swap  = {eb, fb} > {ea, fa};
    assign el    = swap ? eb : ea;
    assign es    = swap ? ea : eb;
    assign fl    = swap ? fb : fa;
    assign fs    = swap ? fa : fb;
    assign sl    = swap ? sb : sa;
    assign diff  = el - es;
    assign ext_s = {1'b1, fs, 3'b000};
    // Lower half collects everything shifted past R; it folds into the sticky bit.
    assign wide  = {ext_s, {M4{1'b0}}} >> diff;

    always_comb begin
        // NOTE: every always_comb output gets a full default first so no path can infer a latch.
        s1_d          = '0;
        s1_d.ctl.sign = sl;
        s1_d.eff_sub  = sa ^ sb;
        s1_d.exp      = el;
        s1_d.man_l    = {1'b1, fl, 3'b000};
        if (int'(diff) >= MAN_W + 3)
            s1_d.man_s = {{(M4-1){1'b0}}, 1'b1};
        else
            s1_d.man_s = {wide[2*M4-1:M4+1], wide[M4] | (|wide[M4-1:0])};

        s1_d.ctl.spec = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;
        if (a_nan || b_nan) begin
            s1_d.ctl.spec_res = QNAN;
            s1_d.ctl.spec_inv = (a_nan & ~fa[MAN_W-1]) | (b_nan & ~fb[MAN_W-1]);
        end else if (a_inf && b_inf && (sa != sb)) begin
            s1_d.ctl.spec_res = QNAN;
            s1_d.ctl.spec_inv = 1'b1;
        end else if (a_inf) begin
            s1_d.ctl.spec_res = {sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (b_inf) begin
            s1_d.ctl.spec_res = {sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (a_zero && b_zero) begin
            s1_d.ctl.spec_res = {sa & sb, {(W-1){1'b0}}};
        end else if (a_zero) begin
            s1_d.ctl.spec_res = {sb, eb, fb};
        end else if (b_zero) begin
            s1_d.ctl.spec_res = {sa, ea, fa};
        end
    end

    // ---------------- S2: magnitude add/sub ----------------
    always_comb begin
        s2_d     = '0;
        s2_d.ctl = s1_q.ctl;
        s2_d.exp = s1_q.exp;
        if (s1_q.eff_sub)
            s2_d.sum = {1'b0, s1_q.man_l} - {1'b0, s1_q.man_s};
        else
            s2_d.sum = {1'b0, s1_q.man_l} + {1'b0, s1_q.man_s};
    end

    // ---------------- S3: normalise ----------------
    logic [LZ_W-1:0] lz;

    always_comb begin
        lz = '0;
        for (int i = 0; i < M4; i++)
            if (s2_q.sum[i]) lz = LZ_W'(M4 - 1 - i);

        s3_d     = '0;
        s3_d.ctl = s2_q.ctl;
        if (s2_q.sum[M4]) begin
            s3_d.norm = {s2_q.sum[M4:2], s2_q.sum[1] | s2_q.sum[0]};
            s3_d.exp  = {2'b00, s2_q.exp} + {{(EE_W-1){1'b0}}, 1'b1};
        end else begin
            s3_d.norm = s2_q.sum[M4-1:0] << lz;
            s3_d.exp  = {2'b00, s2_q.exp} - {{(EE_W-LZ_W){1'b0}}, lz};
        end
    end

    // ---------------- S4: round to nearest even, pack ----------------
    logic            g_bit, r_bit, s_bit, rnd_up, inexact, sum_zero;
    logic [MAN_W:0]  frac_r;       // carry bit means the mantissa rolled over to 10.0
    logic [EE_W-1:0] exp_r;

    assign sum_zero = ~s3_q.norm[M4-1];  // hidden bit is 1 after normalising anything nonzero
    assign g_bit    = s3_q.norm[2];
    assign r_bit    = s3_q.norm[1];
    assign s_bit    = s3_q.norm[0];
    assign rnd_up   = g_bit & (r_bit | s_bit | s3_q.norm[3]);
    assign inexact  = g_bit | r_bit | s_bit;
    assign frac_r   = {1'b0, s3_q.norm[M4-2:3]} + {{MAN_W{1'b0}}, rnd_up};
    assign exp_r    = s3_q.exp + {{(EE_W-1){1'b0}}, frac_r[MAN_W]};

    always_comb begin
        result_d = {s3_q.ctl.sign, exp_r[EXP_W-1:0], frac_r[MAN_W-1:0]};
        flags_d  = {3'b000, inexact};
        if (s3_q.ctl.spec) begin
            result_d = s3_q.ctl.spec_res;
            flags_d  = {s3_q.ctl.spec_inv, 3'b000};
        end else if (sum_zero) begin
            result_d = '0;
            flags_d  = '0;
        end else if (!exp_r[EE_W-1] && (exp_r >= EXP_MAX)) begin
            result_d = {s3_q.ctl.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flags_d  = 4'b0101;
        end else if (exp_r[EE_W-1] || (exp_r == '0)) begin
            result_d = {s3_q.ctl.sign, {(W-1){1'b0}}};
            flags_d  = 4'b0011;
        end
    end

    // ---------------- pipeline registers ----------------
    // NOTE: state registers use non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1          <= 1'b0;
            v2          <= 1'b0;
            v3          <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
        end else if (advance) begin
            v1          <= io.in_valid;
            v2          <= v1;
            v3          <= v2;
            out_valid_q <= v3;
            if (v3) begin
                result_q <= result_d;
                flags_q  <= flags_d;
            end
        end
    end

    // NOTE: datapath stages carry no reset; their contents are ignored until the matching valid bit is set.
    always_ff @(posedge clk) begin
        if (advance) begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Self-checking bench for fp_addsub_pipe (single precision): directed vector table,
// latency/backpressure/reset sequences, and random traffic against an exact-arithmetic model.
module tb_fp_addsub_pipe;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fp_addsub_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) io ();

    fp_addsub_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io.slave)
    );

    typedef struct {
        string       name;
        logic [31:0] res;
        logic [3:0]  flags;
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic        op;
        logic [31:0] res;
        logic [3:0]  flags;
    } vec_t;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_out    = 0;
    exp_t sb_q[$];
    bit   stalled_prev = 0;
    bit   saw_in_stall = 0;
    logic [35:0] held;
    bit   rand_done = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Exact reference: scale both significands to a common grid 32 bits below the larger
    // exponent, add as signed integers, then round the integer to 24 significant bits.
    function automatic longint scaled(input int e, input logic [22:0] f, input int e_hi);
        longint m;
        int d;
        m = longint'({1'b1, f});
        d = e_hi - e;
        if (d <= 32) return m << (32 - d);
        return 64'sd1;  // far below half an ulp: only its nonzero-ness matters
    endfunction

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic op);
        exp_t r;
        logic sa, sb, sign;
        int ea, eb, e_hi, p, sh, e;
        logic [22:0] fa, fb;
        bit a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        longint v, xa, xb;
        logic [63:0] mag, q, rem, half;
        r.name = "model";
        sa = a[31]; sb = b[31] ^ op;
        ea = int'(a[30:23]); eb = int'(b[30:23]);
        fa = a[22:0]; fb = b[22:0];
        a_nan = (ea == 255) && (fa != 0); b_nan = (eb == 255) && (fb != 0);
        a_inf = (ea == 255) && (fa == 0); b_inf = (eb == 255) && (fb == 0);
        a_zero = (ea == 0); b_zero = (eb == 0);
        if (a_nan || b_nan) begin
            r.res = 32'h7FC00000;
            r.flags = ((a_nan && !fa[22]) || (b_nan && !fb[22])) ? 4'b1000 : 4'b0000;
            return r;
        end
        r.flags = 4'b0000;
        if (a_inf && b_inf && (sa != sb)) begin r.res = 32'h7FC00000; r.flags = 4'b1000; return r; end
        if (a_inf) begin r.res = {sa, 8'hFF, 23'd0}; return r; end
        if (b_inf) begin r.res = {sb, 8'hFF, 23'd0}; return r; end
        if (a_zero && b_zero) begin r.res = {sa & sb, 31'd0}; return r; end
        if (a_zero) begin r.res = {sb, b[30:0]}; return r; end
        if (b_zero) begin r.res = {sa, a[30:0]}; return r; end
        e_hi = (ea > eb) ? ea : eb;
        xa = scaled(ea, fa, e_hi);
        xb = scaled(eb, fb, e_hi);
        v = (sa ? -xa : xa) + (sb ? -xb : xb);
        if (v == 0) begin r.res = 32'd0; return r; end
        sign = (v < 0);
        mag = sign ? 64'(-v) : 64'(v);
        p = 0;
        for (int i = 0; i < 64; i++) if (mag[i]) p = i;
        sh = p - 23;
        if (sh > 0) begin
            q = mag >> sh;
            rem = mag & ((64'd1 << sh) - 64'd1);
            half = 64'd1 << (sh - 1);
            if ((rem > half) || ((rem == half) && q[0])) q = q + 64'd1;
        end else begin
            q = mag << (-sh);
            rem = 64'd0;
        end
        e = sh + e_hi - 32;
        if (q == (64'd1 << 24)) begin q = q >> 1; e++; end
        if (e >= 255) begin r.res = {sign, 8'hFF, 23'd0}; r.flags = 4'b0101; end
        else if (e <= 0) begin r.res = {sign, 31'd0}; r.flags = 4'b0011; end
        else begin r.res = {sign, e[7:0], q[22:0]}; r.flags = {3'b000, rem != 0}; end
        return r;
    endfunction

    function automatic logic [31:0] rand_operand(input logic [7:0] near);
        int k, e;
        logic s;
        logic [22:0] f;
        k = int'($urandom_range(0, 19));
        s = 1'($urandom_range(0, 1));
        f = 23'($urandom);
        if (k == 0) return {s, 31'd0};
        if (k == 1) return {s, 8'h00, (f == 0) ? 23'd1 : f};
        if (k == 2) return {s, 8'hFF, 23'd0};
        if (k == 3) return {s, 8'hFF, (f == 0) ? 23'd1 : f};
        if (k <= 11) e = int'(near) + int'($urandom_range(0, 4)) - 2;
        else e = int'($urandom_range(1, 254));
        if (e < 1) e = 1;
        if (e > 254) e = 254;
        return {s, e[7:0], f};
    endfunction

    // Output monitor: sampled on the falling edge, ahead of the rising edge that transfers.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            stalled_prev = 0;
        end else begin
            if (stalled_prev) begin
                check("hold_out_valid", io.out_valid, 1'b1);
                check("hold_result_flags", {io.flags, io.result}, held);
            end
            stalled_prev = io.out_valid && !io.out_ready;
            held = {io.flags, io.result};
            if (io.in_valid && !io.in_ready) saw_in_stall = 1;
            if (io.out_valid && io.out_ready) begin
                n_out++;
                if (sb_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_output: result %h flags %b with nothing pending", io.result, io.flags);
                end else begin
                    e = sb_q.pop_front();
                    check({e.name, "_result"}, io.result, e.res);
                    check({e.name, "_flags"}, io.flags, e.flags);
                end
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic op, input exp_t e);
        int waitc;
        waitc = 0;
        io.a = a; io.b = b; io.op = op; io.in_valid = 1'b1;
        @(negedge clk);
        while (!io.in_ready && waitc < 100) begin @(negedge clk); waitc++; end
        if (!io.in_ready) begin
            n_checks++;
            $display("FAIL in_ready_timeout: in_ready %b after %0d cycles, required 1", io.in_ready, waitc);
        end else begin
            sb_q.push_back(e);
        end
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int c;
        c = 0;
        io.in_valid = 1'b0;
        while (sb_q.size() != 0 && c < 200) begin @(posedge clk); c++; end
        @(posedge clk); #1;
        if (sb_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain_timeout: %0d results pending, required 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[18];
        exp_t e;
        logic [31:0] ra, rb;
        logic rop;
        int lat, n0;

        vecs[0]  = '{"one_plus_one",     32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'h0};
        vecs[1]  = '{"one_minus_one",    32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'h0};
        vecs[2]  = '{"m3_plus_2",        32'hC0400000, 32'h40000000, 1'b0, 32'hBF800000, 4'h0};
        vecs[3]  = '{"tie_even_down",    32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'h1};
        vecs[4]  = '{"tie_even_up",      32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'h1};
        vecs[5]  = '{"inf_minus_inf",    32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'h8};
        vecs[6]  = '{"max_overflow",     32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'h5};
        vecs[7]  = '{"subnorm_plus_0",   32'h00400000, 32'h00000000, 1'b0, 32'h00000000, 4'h0};
        vecs[8]  = '{"snan_in",          32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'h8};
        vecs[9]  = '{"qnan_in",          32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'h0};
        vecs[10] = '{"inf_plus_one",     32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 4'h0};
        vecs[11] = '{"one_minus_inf",    32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 4'h0};
        vecs[12] = '{"zero_minus_one",   32'h00000000, 32'h3F800000, 1'b1, 32'hBF800000, 4'h0};
        vecs[13] = '{"negz_minus_posz",  32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 4'h0};
        vecs[14] = '{"posz_plus_negz",   32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 4'h0};
        vecs[15] = '{"underflow",        32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4'h3};
        vecs[16] = '{"one_plus_subnorm", 32'h3F800000, 32'h00400000, 1'b0, 32'h3F800000, 4'h0};
        vecs[17] = '{"above_tie",        32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 4'h1};

        io.in_valid = 1'b0; io.a = '0; io.b = '0; io.op = 1'b0; io.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", io.out_valid, 1'b0);
        check("rst_result", io.result, 32'h0);
        check("rst_flags", io.flags, 4'h0);
        rst_n = 1'b1;
        check("in_ready_after_rst", io.in_ready, 1'b1);

        // Latency of the first transfer.
        io.a = 32'h3F800000; io.b = 32'h3F800000; io.op = 1'b0; io.in_valid = 1'b1;
        @(negedge clk);
        sb_q.push_back('{"latency_1p1", 32'h40000000, 4'h0});
        @(posedge clk); #1;
        io.in_valid = 1'b0;
        lat = 1;
        while (!io.out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        check("latency_cycles", lat, 4);
        drain();

        // Directed vectors streamed back to back.
        for (int i = 0; i < 18; i++)
            send(vecs[i].a, vecs[i].b, vecs[i].op, '{vecs[i].name, vecs[i].res, vecs[i].flags});
        drain();

        // Backpressure: out_ready low for six cycles in the middle of an 8-op burst.
        n0 = n_out;
        saw_in_stall = 0;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    ra = rand_operand(8'($urandom_range(1, 254)));
                    rb = rand_operand(ra[30:23]);
                    rop = 1'($urandom_range(0, 1));
                    e = model(ra, rb, rop);
                    e.name = "backpressure";
                    send(ra, rb, rop, e);
                end
                io.in_valid = 1'b0;
            end
            begin
                repeat (4) @(posedge clk);
                #1 io.out_ready = 1'b0;
                repeat (6) @(posedge clk);
                #1 io.out_ready = 1'b1;
            end
        join
        drain();
        check("bp_result_count", n_out - n0, 8);
        check("bp_in_ready_fell", saw_in_stall, 1'b1);

        // Reset with three operations in flight, the oldest already presented.
        for (int i = 0; i < 3; i++)
            send(32'h40400000, 32'h3F800000, 1'b0, '{"flushed", 32'h40800000, 4'h0});
        io.in_valid = 1'b0;
        @(posedge clk); #1;
        check("pre_rst_out_valid", io.out_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", io.out_valid, 1'b0);
        check("mid_rst_result", io.result, 32'h0);
        sb_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        n0 = n_out;
        repeat (8) @(posedge clk);
        #1;
        check("no_stale_output", n_out - n0, 0);
        send(32'h3FC00000, 32'h3E800000, 1'b0, '{"post_rst_1p5_0p25", 32'h3FE00000, 4'h0});
        drain();

        // Random traffic with random bubbles and random output backpressure.
        n0 = n_out;
        rand_done = 0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        io.in_valid = 1'b0;
                        @(posedge clk); #1;
                    end
                    ra = rand_operand(8'($urandom_range(1, 254)));
                    rb = rand_operand(ra[30:23]);
                    rop = 1'($urandom_range(0, 1));
                    e = model(ra, rb, rop);
                    e.name = $sformatf("rand_%h_%h_%b", ra, rb, rop);
                    send(ra, rb, rop, e);
                end
                io.in_valid = 1'b0;
                rand_done = 1;
            end
            begin
                while (!rand_done) begin
                    io.out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk); #1;
                end
                io.out_ready = 1'b1;
            end
        join
        drain();
        check("rand_result_count", n_out - n0, 300);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
